// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan path.
// No logic: state encodings, digit count and default timing constants.
// Ports: none (package).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLANCO  = 2'd1,
        MOSTRAR = 2'd2
    } estado_t;

    localparam int NUM_CIFRAS      = 4;
    localparam int DIV_BARRIDO_DEF = 12500;  // 50 MHz -> 4 kHz per digit
    localparam int T_BLANCO_DEF    = 250;    // anti-ghosting blank per slot

endpackage

// File: rtl/controlador_barrido_if.sv
// Groups the scan controller's enable/load inputs and display outputs.
// Latency: none (wires only). Backpressure: none, outputs are free-running.
// Ports: master drives i_* and reads o_*; slave is the controller side.
interface controlador_barrido_if;
    import display_pkg::*;

    logic       i_Habilitar;
    logic       i_Cargar;
    logic [3:0] i_Datos1;
    logic [3:0] i_Datos2;
    logic [3:0] i_Datos3;
    logic [3:0] i_Datos4;
    logic [1:0] o_N_cifra;
    logic [3:0] o_Datos1;
    logic [3:0] o_Datos2;
    logic [3:0] o_Datos3;
    logic [3:0] o_Datos4;
    logic       o_Blanco;
    logic       o_Fin_trama;

    modport master (
        output i_Habilitar, i_Cargar, i_Datos1, i_Datos2, i_Datos3, i_Datos4,
        input  o_N_cifra, o_Datos1, o_Datos2, o_Datos3, o_Datos4, o_Blanco, o_Fin_trama
    );

    modport slave (
        input  i_Habilitar, i_Cargar, i_Datos1, i_Datos2, i_Datos3, i_Datos4,
        output o_N_cifra, o_Datos1, o_Datos2, o_Datos3, o_Datos4, o_Blanco, o_Fin_trama
    );

endinterface

// File: rtl/controlador_barrido_prescaler.sv
// Per-digit slot prescaler: counts 0..DIV_BARRIDO-1 and wraps.
// Latency: flags are combinational from the count register. Backpressure: none.
// Ports: i_Clk, i_Rst_n, i_Clr (sync clear), o_Tc (last slot cycle), o_Fin_blanco (last blanked cycle).
module prescaler_barrido
    import display_pkg::*;
#(
    parameter int DIV_BARRIDO = DIV_BARRIDO_DEF,
    parameter int T_BLANCO    = T_BLANCO_DEF,
    localparam int ANCHO_CONT = $clog2(DIV_BARRIDO)
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clr,
    output logic o_Tc,
    output logic o_Fin_blanco
);

    localparam logic [ANCHO_CONT-1:0] ULTIMO     = ANCHO_CONT'(DIV_BARRIDO - 1);
    // With no blanking this value is never used (flag forced low below).
    localparam logic [ANCHO_CONT-1:0] ULT_BLANCO = ANCHO_CONT'((T_BLANCO == 0) ? 0 : T_BLANCO - 1);

    logic [ANCHO_CONT-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q + ANCHO_CONT'(1);
        if (i_Clr || o_Tc) begin
            cont_d = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign o_Tc         = (cont_q == ULTIMO);
    // Marks the last count still below T_BLANCO, i.e. the blank ends after it.
    assign o_Fin_blanco = (T_BLANCO != 0) && (cont_q == ULT_BLANCO);

endmodule

// File: rtl/controlador_barrido.sv
// Scan controller: steps the digit index per slot, blanks each slot start, double-buffers data per frame.
// Latency: all outputs registered, one cycle after the deciding edge. Backpressure: none; loads always accepted.
// Ports: i_Clk, i_Rst_n (async, active-low), bus (slave modport: enable/load/data in, digit/data/blank/frame out).
module controlador_barrido
    import display_pkg::*;
#(
    parameter int DIV_BARRIDO = DIV_BARRIDO_DEF,
    parameter int T_BLANCO    = T_BLANCO_DEF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    controlador_barrido_if.slave  bus
);

    // Without a blanking interval every slot starts directly in MOSTRAR.
    localparam estado_t    ARRANQUE  = (T_BLANCO == 0) ? MOSTRAR : BLANCO;
    localparam logic [1:0] ULT_CIFRA = 2'(NUM_CIFRAS - 1);

    estado_t                         estado_q, estado_d;
    logic [1:0]                      cifra_q, cifra_d;
    logic [NUM_CIFRAS-1:0][3:0]      datos_q, datos_d;
    logic [NUM_CIFRAS-1:0][3:0]      pend_q, pend_d;
    logic                            pend_vld_q, pend_vld_d;
    logic                            blanco_q, blanco_d;
    logic                            fin_q, fin_d;
    logic                            borde_trama;
    logic                            presc_clr, presc_tc, presc_fin_blanco;
    logic [NUM_CIFRAS-1:0][3:0]      entrada;

    assign entrada = {bus.i_Datos4, bus.i_Datos3, bus.i_Datos2, bus.i_Datos1};

    // Held at 0 in IDLE so the first slot after enabling starts from count 0,
    // and cleared on the cycle enable drops so IDLE is entered with count 0.
    assign presc_clr = (estado_q == IDLE) || !bus.i_Habilitar;

    prescaler_barrido #(
        .DIV_BARRIDO (DIV_BARRIDO),
        .T_BLANCO    (T_BLANCO)
    ) u_prescaler (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Clr        (presc_clr),
        .o_Tc         (presc_tc),
        .o_Fin_blanco (presc_fin_blanco)
    );

    always_comb begin
        estado_d    = estado_q;
        cifra_d     = cifra_q;
        datos_d     = datos_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        borde_trama = 1'b0;

        case (estado_q)
            IDLE: begin
                if (bus.i_Habilitar) begin
                    estado_d = ARRANQUE;
                end
            end
            BLANCO: begin
                if (presc_fin_blanco) begin
                    estado_d = MOSTRAR;
                end
            end
            MOSTRAR: begin
                if (presc_tc) begin
                    estado_d    = ARRANQUE;
                    cifra_d     = cifra_q + 2'd1;
                    borde_trama = (cifra_q == ULT_CIFRA);
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        // Disable wins over everything; an abandoned frame never counts as a wrap.
        if (!bus.i_Habilitar) begin
            estado_d    = IDLE;
            cifra_d     = 2'd0;
            borde_trama = 1'b0;
        end

        // Double buffer: data only reaches the outputs on a frame wrap.
        // A load coinciding with the wrap bypasses the pending buffer.
        if (borde_trama) begin
            if (bus.i_Cargar) begin
                datos_d = entrada;
            end else if (pend_vld_q) begin
                datos_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.i_Cargar) begin
            pend_d     = entrada;
            pend_vld_d = 1'b1;
        end

        fin_d    = borde_trama;
        blanco_d = (estado_d != MOSTRAR);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            estado_q   <= IDLE;
            cifra_q    <= 2'd0;
            datos_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            blanco_q   <= 1'b1;
            fin_q      <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cifra_q    <= cifra_d;
            datos_q    <= datos_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            blanco_q   <= blanco_d;
            fin_q      <= fin_d;
        end
    end

    assign bus.o_N_cifra   = cifra_q;
    assign bus.o_Datos1    = datos_q[0];
    assign bus.o_Datos2    = datos_q[1];
    assign bus.o_Datos3    = datos_q[2];
    assign bus.o_Datos4    = datos_q[3];
    assign bus.o_Blanco    = blanco_q;
    assign bus.o_Fin_trama = fin_q;

endmodule

// File: tb/tb_controlador_barrido.sv
module tb_controlador_barrido;

    localparam int D     = 8;
    localparam int T     = 2;
    localparam int TRAMA = 4 * D;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    controlador_barrido_if bif ();
    controlador_barrido_if bif2 ();

    controlador_barrido #(.DIV_BARRIDO(D), .T_BLANCO(T)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bif)
    );

    controlador_barrido #(.DIV_BARRIDO(D), .T_BLANCO(0)) dut2 (
        .i_Clk   (clk),
        .i_Rst_n (rst2_n),
        .bus     (bif2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: time-based view of the scan. m_n counts cycles since
    // scanning started; slot, digit and blank follow from plain division.
    int          m_n;
    bit          m_act;
    bit          m_fin;
    logic [15:0] m_dat;
    logic [15:0] m_pend;
    bit          m_pv;

    function automatic void model_reset();
        m_n = 0; m_act = 0; m_fin = 0; m_dat = '0; m_pend = '0; m_pv = 0;
    endfunction

    function automatic void model_edge(input bit hab, input bit car, input logic [15:0] din);
        bit wrap;
        wrap = 0;
        if (hab) begin
            m_n   = m_act ? m_n + 1 : 0;
            m_act = 1;
            wrap  = (m_n > 0) && (m_n % TRAMA == 0);
        end else begin
            m_act = 0;
            m_n   = 0;
        end
        if (wrap) begin
            if (car)       m_dat = din;
            else if (m_pv) m_dat = m_pend;
            m_pv = 0;
        end else if (car) begin
            m_pend = din;
            m_pv   = 1;
        end
        m_fin = wrap;
    endfunction

    function automatic logic [1:0] exp_cifra();
        return m_act ? 2'((m_n / D) % 4) : 2'd0;
    endfunction

    function automatic logic exp_blanco();
        return m_act ? ((m_n % D) < T) : 1'b1;
    endfunction

    function automatic logic [15:0] dut_dat();
        return {bif.o_Datos1, bif.o_Datos2, bif.o_Datos3, bif.o_Datos4};
    endfunction

    function automatic logic [15:0] dut2_dat();
        return {bif2.o_Datos1, bif2.o_Datos2, bif2.o_Datos3, bif2.o_Datos4};
    endfunction

    // One clock of the main DUT: drive, clock, advance model, sample at negedge.
    task automatic tick(input bit hab, input bit car, input logic [15:0] din);
        bif.i_Habilitar = hab;
        bif.i_Cargar    = car;
        {bif.i_Datos1, bif.i_Datos2, bif.i_Datos3, bif.i_Datos4} = din;
        @(posedge clk);
        model_edge(hab, car, din);
        @(negedge clk);
        chk("model_cifra",  32'(bif.o_N_cifra),   32'(exp_cifra()));
        chk("model_blanco", 32'(bif.o_Blanco),    32'(exp_blanco()));
        chk("model_fin",    32'(bif.o_Fin_trama), 32'(m_fin));
        chk("model_datos",  32'(dut_dat()),       32'(m_dat));
    endtask

    typedef struct {
        bit          hab;
        bit          car;
        logic [15:0] din;
        int          k;       // edges to apply; load only on the first
        logic [1:0]  cifra;
        bit          blanco;
        bit          fin;
        logic [15:0] dat;
    } vec_t;

    vec_t tab[$];

    initial begin
        // Directed vectors, D=8 T=2; comments give scan cycle n after the step.
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 0, 16'h0000}); // n0
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 0, 16'h0000}); // n1
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 0, 0, 16'h0000}); // n2 blank ends
        tab.push_back('{1, 0, 16'h0000,  6, 2'd1, 1, 0, 16'h0000}); // n8 digit 1
        tab.push_back('{1, 1, 16'h1234,  3, 2'd1, 0, 0, 16'h0000}); // n11 load pending
        tab.push_back('{1, 0, 16'h0000, 20, 2'd3, 0, 0, 16'h0000}); // n31
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 1, 16'h1234}); // n32 wrap commit
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 0, 16'h1234}); // n33 single pulse
        tab.push_back('{1, 1, 16'h5678,  1, 2'd0, 0, 0, 16'h1234}); // n34
        tab.push_back('{1, 1, 16'h9ABC,  1, 2'd0, 0, 0, 16'h1234}); // n35 overwrite
        tab.push_back('{1, 0, 16'h0000, 28, 2'd3, 0, 0, 16'h1234}); // n63
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 1, 16'h9ABC}); // n64 last write wins
        tab.push_back('{1, 1, 16'h1111, 31, 2'd3, 0, 0, 16'h9ABC}); // n95
        tab.push_back('{1, 1, 16'hFFFF,  1, 2'd0, 1, 1, 16'hFFFF}); // n96 load on wrap
        tab.push_back('{1, 0, 16'h0000, 32, 2'd0, 1, 1, 16'hFFFF}); // n128 no 2nd commit
        tab.push_back('{1, 0, 16'h0000, 21, 2'd2, 0, 0, 16'hFFFF}); // n149 digit2 cnt5
        tab.push_back('{0, 0, 16'h0000,  1, 2'd0, 1, 0, 16'hFFFF}); // disabled
        tab.push_back('{0, 1, 16'h2468,  3, 2'd0, 1, 0, 16'hFFFF}); // load while idle
        tab.push_back('{1, 0, 16'h0000,  1, 2'd0, 1, 0, 16'hFFFF}); // n0 restart
        tab.push_back('{1, 0, 16'h0000,  7, 2'd0, 0, 0, 16'hFFFF}); // n7 full slot 0
        tab.push_back('{1, 0, 16'h0000,  1, 2'd1, 1, 0, 16'hFFFF}); // n8
        tab.push_back('{1, 0, 16'h0000, 24, 2'd0, 1, 1, 16'h2468}); // n32 idle load commits

        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bif.i_Habilitar = 0; bif.i_Cargar = 0;
        {bif.i_Datos1, bif.i_Datos2, bif.i_Datos3, bif.i_Datos4} = '0;
        bif2.i_Habilitar = 0; bif2.i_Cargar = 0;
        {bif2.i_Datos1, bif2.i_Datos2, bif2.i_Datos3, bif2.i_Datos4} = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_cifra",  32'(bif.o_N_cifra),   32'd0);
        chk("rst_blanco", 32'(bif.o_Blanco),    32'd1);
        chk("rst_fin",    32'(bif.o_Fin_trama), 32'd0);
        chk("rst_datos",  32'(dut_dat()),       32'd0);

        foreach (tab[i]) begin
            tick(tab[i].hab, tab[i].car, tab[i].din);
            for (int j = 1; j < tab[i].k; j++) tick(tab[i].hab, 1'b0, tab[i].din);
            chk($sformatf("vec%0d_cifra", i),  32'(bif.o_N_cifra),   32'(tab[i].cifra));
            chk($sformatf("vec%0d_blanco", i), 32'(bif.o_Blanco),    32'(tab[i].blanco));
            chk($sformatf("vec%0d_fin", i),    32'(bif.o_Fin_trama), 32'(tab[i].fin));
            chk($sformatf("vec%0d_datos", i),  32'(dut_dat()),       32'(tab[i].dat));
        end

        // Randomized traffic against the model: rare disables, frequent loads.
        for (int r = 0; r < 2500; r++) begin
            tick($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, 16'($urandom));
        end

        // Main DUT parked; exercise the no-blanking instance.
        bif.i_Habilitar = 0; bif.i_Cargar = 0;
        rst2_n = 1'b1;
        @(negedge clk);
        chk("t0_rst_blanco", 32'(bif2.o_Blanco), 32'd1);
        for (int n = 0; n < 36; n++) begin
            bif2.i_Habilitar = 1;
            bif2.i_Cargar    = (n == 0);
            {bif2.i_Datos1, bif2.i_Datos2, bif2.i_Datos3, bif2.i_Datos4} = 16'h5A5A;
            @(negedge clk);
            chk($sformatf("t0_blanco_n%0d", n), 32'(bif2.o_Blanco), 32'd0);
            chk($sformatf("t0_cifra_n%0d", n), 32'(bif2.o_N_cifra), 32'((n / D) % 4));
            chk($sformatf("t0_fin_n%0d", n), 32'(bif2.o_Fin_trama), 32'(n == TRAMA));
        end
        chk("t0_datos_before_rst", 32'(dut2_dat()), 32'h5A5A);

        // Asynchronous reset between clock edges.
        #2;
        rst2_n = 1'b0;
        #1;
        chk("arst_blanco", 32'(bif2.o_Blanco),    32'd1);
        chk("arst_cifra",  32'(bif2.o_N_cifra),   32'd0);
        chk("arst_fin",    32'(bif2.o_Fin_trama), 32'd0);
        chk("arst_datos",  32'(dut2_dat()),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
